// File: rtl/decode_issue_stage_pkg.sv
// Shared types for the ID stage: pipeline payloads, forwarding source and decoder output.
package decode_issue_stage_pkg;

  typedef logic [2:0]  u3;
  typedef logic [3:0]  u4;
  typedef logic [4:0]  u5;
  typedef logic [63:0] u64;

  localparam u5 REG_ZERO = 5'd0;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef struct packed {
    logic [31:0] instr;
    u64          pc;
    u64          pcPlus4;
    u64          instrAddr;
  } REG_IF_ID;

  typedef struct packed {
    logic valid;
    logic isWb;
    u5    wd;
    u64   wdData;
  } FORWARD_SOURCE;

  typedef struct packed {
    u64   imm;
    u5    wd;
    u4    aluOp;
    u3    mulOp;
    logic srcA;
    logic srcB;
    logic isBranch;
    logic isWriteBack;
    logic isMemRead;
    logic isMemWrite;
    u3    memMode;
    logic rv64;
    logic rvm;
    logic cns;
    logic useflag;
    logic flagInv;
  } DECODE_OUT;

  typedef struct packed {
    u64   pc;
    u64   pcPlus4;
    u64   instrAddr;
    u64   rs1;
    u64   rs2;
    u64   imm;
    u5    wd;
    u4    aluOp;
    u3    mulOp;
    logic srcA;
    logic srcB;
    logic isBranch;
    logic isWriteBack;
    logic isMemRead;
    logic isMemWrite;
    u3    memMode;
    logic rv64;
    logic rvm;
    logic cns;
    logic useflag;
    logic flagInv;
  } REG_ID_EX;

  // alt (instr[30]) selects SUB only for register-register forms; shifts use it for SRA.
  function automatic u4 alu_decode(input u3 f3, input logic alt, input logic is_reg);
    case (f3)
      3'b000:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_issue_stage_if.sv
// IF/ID -> ID/EX handshake bundle plus register-file and forwarding taps of the ID stage.
interface decode_issue_stage_if
  import decode_issue_stage_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int XLEN    = 64
);
  logic                         in_valid;
  logic                         in_ready;
  REG_IF_ID                     moduleIn;
  u5                            rs1;
  u5                            rs2;
  logic [XLEN-1:0]              rs1Data;
  logic [XLEN-1:0]              rs2Data;
  FORWARD_SOURCE [NUM_FWD-1:0]  fwd;
  logic                         flush;
  logic                         out_valid;
  logic                         out_ready;
  REG_ID_EX                     moduleOut;
  logic                         ldHold;
  logic                         hazard;

  modport slave (
    input  in_valid, moduleIn, rs1Data, rs2Data, fwd, flush, out_ready,
    output in_ready, rs1, rs2, out_valid, moduleOut, ldHold, hazard
  );

  modport master (
    output in_valid, moduleIn, rs1Data, rs2Data, fwd, flush, out_ready,
    input  in_ready, rs1, rs2, out_valid, moduleOut, ldHold, hazard
  );
endinterface

// File: rtl/decode_issue_stage_fwd_select.sv
// NUM_FWD-way priority forwarding mux; index 0 is youngest and wins, x0 always reads zero.
module fwd_select
  import decode_issue_stage_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int XLEN    = 64
)(
  input  u5                           rs_i,
  input  logic [XLEN-1:0]             rf_data_i,
  input  FORWARD_SOURCE [NUM_FWD-1:0] fwd_i,
  output logic [XLEN-1:0]             data_o
);
  always_comb begin
    data_o = rf_data_i;
    // Walk oldest to youngest so the lowest matching index is the last writer.
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_i[i].valid && fwd_i[i].isWb && (fwd_i[i].wd == rs_i) && (fwd_i[i].wd != REG_ZERO))
        data_o = fwd_i[i].wdData[XLEN-1:0];
    end
    if (rs_i == REG_ZERO) data_o = '0;
  end
endmodule

// File: rtl/maindecoder.sv
// RV64IM main decoder: immediate extraction and control fields for the ID/EX payload.
module maindecoder
  import decode_issue_stage_pkg::*;
(
  input  logic [31:0] instr_i,
  output DECODE_OUT   dec_o
);
  logic [6:0] opc;
  u3          f3;
  u64         imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc   = instr_i[6:0];
  assign f3    = instr_i[14:12];
  assign imm_i = {{52{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{51{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
  assign imm_j = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    dec_o = '0;
    case (opc)
      OPC_OP_IMM, OPC_OP_IMM32: begin
        dec_o.imm         = imm_i;
        dec_o.aluOp       = alu_decode(f3, instr_i[30], 1'b0);
        dec_o.srcB        = 1'b1;
        dec_o.isWriteBack = 1'b1;
        dec_o.rv64        = (opc == OPC_OP_IMM32);
      end
      OPC_OP, OPC_OP32: begin
        dec_o.aluOp       = alu_decode(f3, instr_i[30], 1'b1);
        dec_o.mulOp       = f3;
        dec_o.rvm         = (instr_i[31:25] == 7'b0000001);
        dec_o.isWriteBack = 1'b1;
        dec_o.rv64        = (opc == OPC_OP32);
      end
      OPC_LOAD: begin
        dec_o.imm         = imm_i;
        dec_o.srcB        = 1'b1;
        dec_o.isWriteBack = 1'b1;
        dec_o.isMemRead   = 1'b1;
        dec_o.memMode     = f3;
      end
      OPC_STORE: begin
        dec_o.imm        = imm_s;
        dec_o.srcB       = 1'b1;
        dec_o.isMemWrite = 1'b1;
        dec_o.memMode    = f3;
      end
      OPC_BRANCH: begin
        // Compare result drives the flag; odd funct3 inverts it, funct3[1] means unsigned.
        dec_o.imm      = imm_b;
        dec_o.aluOp    = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        dec_o.isBranch = 1'b1;
        dec_o.useflag  = 1'b1;
        dec_o.flagInv  = f3[0];
        dec_o.cns      = f3[1];
      end
      OPC_LUI: begin
        dec_o.imm         = imm_u;
        dec_o.aluOp       = ALU_PASSB;
        dec_o.srcB        = 1'b1;
        dec_o.isWriteBack = 1'b1;
      end
      OPC_AUIPC: begin
        dec_o.imm         = imm_u;
        dec_o.srcA        = 1'b1;
        dec_o.srcB        = 1'b1;
        dec_o.isWriteBack = 1'b1;
      end
      OPC_JAL: begin
        dec_o.imm         = imm_j;
        dec_o.srcA        = 1'b1;
        dec_o.srcB        = 1'b1;
        dec_o.isBranch    = 1'b1;
        dec_o.isWriteBack = 1'b1;
      end
      OPC_JALR: begin
        dec_o.imm         = imm_i;
        dec_o.srcB        = 1'b1;
        dec_o.isBranch    = 1'b1;
        dec_o.isWriteBack = 1'b1;
      end
      default: ;
    endcase
    dec_o.wd = dec_o.isWriteBack ? instr_i[11:7] : REG_ZERO;
  end
endmodule

// File: rtl/decode_issue_stage.sv
// ID stage: decode, operand forwarding, load-use bubble insertion, registered ID/EX payload.
// DECODE_LOADUSE_INTERLOCK_EN enables the local interlock; otherwise the legacy ldHold is driven.
module decode_issue_stage
  import decode_issue_stage_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int XLEN    = 64
)(
  input logic                 clk,
  input logic                 rst,
  decode_issue_stage_if.slave io
);
  DECODE_OUT              dec;
  logic [1:0][4:0]        rs_addr;
  logic [1:0][XLEN-1:0]   rf_data;
  logic [1:0][XLEN-1:0]   opnd;
  REG_ID_EX               pl, out_d, out_q;
  logic                   vld_d, vld_q;
  logic                   hazard, in_ready;

  maindecoder u_dec (.instr_i(io.moduleIn.instr), .dec_o(dec));

  assign rs_addr[0] = io.moduleIn.instr[19:15];
  assign rs_addr[1] = io.moduleIn.instr[24:20];
  assign rf_data[0] = io.rs1Data;
  assign rf_data[1] = io.rs2Data;
  assign io.rs1     = rs_addr[0];
  assign io.rs2     = rs_addr[1];

  for (genvar g = 0; g < 2; g++) begin : g_opnd
    fwd_select #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_fwd (
      .rs_i     (rs_addr[g]),
      .rf_data_i(rf_data[g]),
      .fwd_i    (io.fwd),
      .data_o   (opnd[g])
    );
  end

`ifdef DECODE_LOADUSE_INTERLOCK_EN
  assign hazard = vld_q & out_q.isMemRead & out_q.isWriteBack & (out_q.wd != REG_ZERO) & io.in_valid &
                  ((out_q.wd == rs_addr[0]) | (out_q.wd == rs_addr[1]));
  assign io.ldHold = 1'b0;
`else
  assign hazard    = 1'b0;
  assign io.ldHold = io.in_valid & dec.isMemRead;
`endif

  assign in_ready     = io.flush | (~hazard & (~vld_q | io.out_ready));
  assign io.in_ready  = in_ready;
  assign io.hazard    = hazard;
  assign io.out_valid = vld_q;
  assign io.moduleOut = out_q;

  always_comb begin
    pl             = '0;
    pl.pc          = io.moduleIn.pc;
    pl.pcPlus4     = io.moduleIn.pcPlus4;
    pl.instrAddr   = io.moduleIn.instrAddr;
    pl.rs1         = opnd[0];
    pl.rs2         = opnd[1];
    pl.imm         = dec.imm;
    pl.wd          = dec.wd;
    pl.aluOp       = dec.aluOp;
    pl.mulOp       = dec.mulOp;
    pl.srcA        = dec.srcA;
    pl.srcB        = dec.srcB;
    pl.isBranch    = dec.isBranch;
    pl.isWriteBack = dec.isWriteBack;
    pl.isMemRead   = dec.isMemRead;
    pl.isMemWrite  = dec.isMemWrite;
    pl.memMode     = dec.memMode;
    pl.rv64        = dec.rv64;
    pl.rvm         = dec.rvm;
    pl.cns         = dec.cns;
    pl.useflag     = dec.useflag;
    pl.flagInv     = dec.flagInv;
  end

  // Flush drops the incoming payload too: in_ready is forced high but nothing is loaded.
  always_comb begin
    vld_d = vld_q;
    out_d = out_q;
    if (io.flush) begin
      vld_d = 1'b0;
    end else if (hazard && io.out_ready) begin
      vld_d = 1'b0;
    end else if (io.in_valid && in_ready) begin
      vld_d = 1'b1;
      out_d = pl;
    end else if (io.out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_q <= 1'b0;
    else      vld_q <= vld_d;
  end

  always_ff @(posedge clk) out_q <= out_d;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Randomised + directed bench for decode_issue_stage against a behavioural ID-stage model.
module tb_decode_issue_stage;
  import decode_issue_stage_pkg::*;

  localparam int NF = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_issue_stage_if #(.NUM_FWD(NF), .XLEN(64)) io();
  decode_issue_stage #(.NUM_FWD(NF), .XLEN(64)) dut (.clk(clk), .rst(rst), .io(io));

  typedef struct {
    logic [31:0] raw;
    u5           wd;
    u64          imm;
    bit          ld;
    bit          wb;
  } ins_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  ins_t cur;
  bit   m_vld, m_ld, m_wb, last_acc;
  u64   m_pc, m_a, m_b, m_imm;
  u5    m_wd;

  function automatic u64 sext12(input logic [11:0] i);
    return {{52{i[11]}}, i};
  endfunction

  function automatic ins_t mk_addi(input u5 rd, input u5 rs1, input logic [11:0] im);
    ins_t r;
    r.raw = {im, rs1, 3'b000, rd, 7'b0010011};
    r.wd = rd; r.imm = sext12(im); r.ld = 0; r.wb = 1;
    return r;
  endfunction

  function automatic ins_t mk_add(input u5 rd, input u5 rs1, input u5 rs2);
    ins_t r;
    r.raw = {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    r.wd = rd; r.imm = '0; r.ld = 0; r.wb = 1;
    return r;
  endfunction

  function automatic ins_t mk_ld(input u5 rd, input u5 rs1, input logic [11:0] im);
    ins_t r;
    r.raw = {im, rs1, 3'b011, rd, 7'b0000011};
    r.wd = rd; r.imm = sext12(im); r.ld = 1; r.wb = 1;
    return r;
  endfunction

  function automatic ins_t mk_sd(input u5 rs2, input u5 rs1, input logic [11:0] im);
    ins_t r;
    r.raw = {im[11:5], rs2, rs1, 3'b011, im[4:0], 7'b0100011};
    r.wd = '0; r.imm = sext12(im); r.ld = 0; r.wb = 0;
    return r;
  endfunction

  function automatic ins_t rand_ins();
    u5 a = 5'($urandom_range(0, 7));
    u5 b = 5'($urandom_range(0, 7));
    u5 c = 5'($urandom_range(0, 7));
    logic [11:0] im = 12'($urandom);
    case ($urandom_range(0, 3))
      0:       return mk_addi(a, b, im);
      1:       return mk_add(a, b, c);
      2:       return mk_ld(a, b, im);
      default: return mk_sd(a, b, im);
    endcase
  endfunction

  // Youngest matching source wins; x0 is never forwarded.
  function automatic u64 resolve(input u5 r, input u64 rf);
    if (r == 0) return '0;
    for (int i = 0; i < NF; i++)
      if (io.fwd[i].valid && io.fwd[i].isWb && io.fwd[i].wd == r) return io.fwd[i].wdData;
    return rf;
  endfunction

  function automatic bit exp_hazard();
`ifdef DECODE_LOADUSE_INTERLOCK_EN
    return m_vld && m_ld && m_wb && (m_wd != 0) && io.in_valid &&
           (m_wd == cur.raw[19:15] || m_wd == cur.raw[24:20]);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_ldhold();
`ifdef DECODE_LOADUSE_INTERLOCK_EN
    return 1'b0;
`else
    return io.in_valid && cur.ld;
`endif
  endfunction

  function automatic bit exp_rdy();
    return io.flush || (!exp_hazard() && (!m_vld || io.out_ready));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("in_ready",  64'(io.in_ready),  64'(exp_rdy()));
    chk("hazard",    64'(io.hazard),    64'(exp_hazard()));
    chk("ldHold",    64'(io.ldHold),    64'(exp_ldhold()));
    chk("rs1_addr",  64'(io.rs1),       64'(cur.raw[19:15]));
    chk("rs2_addr",  64'(io.rs2),       64'(cur.raw[24:20]));
    chk("out_valid", 64'(io.out_valid), 64'(m_vld));
    if (m_vld) begin
      chk("pc",      io.moduleOut.pc,                 m_pc);
      chk("wd",      64'(io.moduleOut.wd),            64'(m_wd));
      chk("imm",     io.moduleOut.imm,                m_imm);
      chk("memRead", 64'(io.moduleOut.isMemRead),     64'(m_ld));
      chk("wb",      64'(io.moduleOut.isWriteBack),   64'(m_wb));
      chk("opA",     io.moduleOut.rs1,                m_a);
      chk("opB",     io.moduleOut.rs2,                m_b);
    end
  endtask

  task automatic advance();
    bit hz  = exp_hazard();
    bit rdy = exp_rdy();
    last_acc = io.in_valid && rdy;
    if (io.flush) m_vld = 0;
    else if (hz && io.out_ready) m_vld = 0;
    else if (io.in_valid && rdy) begin
      m_vld = 1;
      m_pc  = io.moduleIn.pc;
      m_a   = resolve(cur.raw[19:15], io.rs1Data);
      m_b   = resolve(cur.raw[24:20], io.rs2Data);
      m_imm = cur.imm; m_wd = cur.wd; m_ld = cur.ld; m_wb = cur.wb;
    end else if (io.out_ready) m_vld = 0;
  endtask

  // Inputs are driven at the negedge; check and step the model just before the posedge.
  task automatic tick();
    #1;
    check_model();
    advance();
    @(negedge clk);
  endtask

  task automatic present(input ins_t i);
    u64 pc = {32'($urandom), 32'($urandom)} & ~64'h3;
    cur = i;
    io.moduleIn.instr     = i.raw;
    io.moduleIn.pc        = pc;
    io.moduleIn.pcPlus4   = pc + 64'd4;
    io.moduleIn.instrAddr = pc;
    io.in_valid = 1'b1;
  endtask

  task automatic set_fwd(input int i, input bit v, input bit wb, input u5 wd, input u64 d);
    io.fwd[i].valid  = v;
    io.fwd[i].isWb   = wb;
    io.fwd[i].wd     = wd;
    io.fwd[i].wdData = d;
  endtask

  initial begin
    io.in_valid = 1'b0; io.flush = 1'b0; io.out_ready = 1'b1;
    io.rs1Data = '0; io.rs2Data = '0; io.fwd = '0;
    m_vld = 0; last_acc = 0;
    present(mk_addi(5'd5, 5'd0, 12'd7));
    #1 rst = 1'b0;

    // reset with a valid payload waiting
    @(negedge clk); #1;
    chk("rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("rst_in_ready",  64'(io.in_ready),  64'd1);
    chk("rst_hazard",    64'(io.hazard),    64'd0);
    chk("rst_ldHold",    64'(io.ldHold),    64'd0);
    @(negedge clk); rst = 1'b1;
    tick();
    chk("addi_valid", 64'(io.out_valid), 64'd1);
    chk("addi_imm",   io.moduleOut.imm,  64'd7);
    chk("addi_wd",    64'(io.moduleOut.wd), 64'd5);

    // forwarding priority
    present(mk_add(5'd1, 5'd3, 5'd3));
    io.rs1Data = 64'h11; io.rs2Data = 64'h22;
    set_fwd(0, 1, 1, 5'd3, 64'hAA);
    set_fwd(1, 1, 1, 5'd3, 64'hBB);
    tick();
    chk("prio_rs1", io.moduleOut.rs1, 64'hAA);
    chk("prio_rs2", io.moduleOut.rs2, 64'hAA);
    present(mk_add(5'd1, 5'd3, 5'd3));
    io.fwd[0].valid = 1'b0;
    tick();
    chk("old_rs1", io.moduleOut.rs1, 64'hBB);
    chk("old_rs2", io.moduleOut.rs2, 64'hBB);

    // x0 guard
    present(mk_add(5'd1, 5'd0, 5'd0));
    io.rs1Data = 64'h55; io.rs2Data = 64'h55;
    io.fwd = '0;
    set_fwd(0, 1, 1, 5'd0, 64'hFF);
    tick();
    chk("x0_rs1", io.moduleOut.rs1, 64'd0);
    chk("x0_rs2", io.moduleOut.rs2, 64'd0);

    // load followed by a dependent add
    io.fwd = '0;
    present(mk_ld(5'd7, 5'd2, 12'd0));
    #1;
`ifndef DECODE_LOADUSE_INTERLOCK_EN
    chk("legacy_ldHold", 64'(io.ldHold), 64'd1);
    chk("legacy_hazard", 64'(io.hazard), 64'd0);
`endif
    tick();
    present(mk_add(5'd8, 5'd7, 5'd1));
`ifdef DECODE_LOADUSE_INTERLOCK_EN
    #1;
    chk("lu_hazard",   64'(io.hazard),   64'd1);
    chk("lu_in_ready", 64'(io.in_ready), 64'd0);
    tick();
    chk("lu_bubble",   64'(io.out_valid), 64'd0);
    set_fwd(0, 1, 1, 5'd7, 64'h1234);
    #1 chk("lu_hazard_drop", 64'(io.hazard), 64'd0);
    tick();
    chk("lu_issue",    64'(io.out_valid), 64'd1);
    chk("lu_issue_wd", 64'(io.moduleOut.wd), 64'd8);
    chk("lu_fwd_x7",   io.moduleOut.rs1, 64'h1234);
`else
    tick();
    chk("legacy_no_bubble", 64'(io.out_valid), 64'd1);
    chk("legacy_add_wd",    64'(io.moduleOut.wd), 64'd8);
`endif

    // back-pressure, then flush
    io.fwd = '0;
    present(mk_addi(5'd9, 5'd1, 12'h010));
    tick();
    io.out_ready = 1'b0;
    present(mk_add(5'd2, 5'd3, 5'd4));
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("bp_in_ready", 64'(io.in_ready), 64'd0);
      chk("bp_wd",       64'(io.moduleOut.wd), 64'd9);
      chk("bp_imm",      io.moduleOut.imm, 64'h10);
    end
    io.flush = 1'b1;
    #1 chk("flush_in_ready", 64'(io.in_ready), 64'd1);
    tick();
    io.flush = 1'b0;
    chk("flush_out_valid", 64'(io.out_valid), 64'd0);

    // randomised traffic
    last_acc = 1;
    for (int n = 0; n < 1500; n++) begin
      if (last_acc || !io.in_valid) begin
        present(rand_ins());
        io.in_valid = ($urandom_range(0, 3) != 0);
      end
      io.out_ready = ($urandom_range(0, 3) != 0);
      io.flush     = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NF; i++)
        set_fwd(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)), {32'($urandom), 32'($urandom)});
      io.rs1Data = {32'($urandom), 32'($urandom)};
      io.rs2Data = {32'($urandom), 32'($urandom)};
      tick();
    end

    // asynchronous reset while stalled
    io.flush = 1'b0; io.out_ready = 1'b1; io.fwd = '0;
    present(mk_ld(5'd3, 5'd1, 12'd0));
    tick();
    io.out_ready = 1'b0;
    present(mk_add(5'd4, 5'd3, 5'd3));
    tick();
    chk("stall_held", 64'(io.out_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid",    64'(io.out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(io.in_ready),  64'd1);
    chk("async_rst_hazard",   64'(io.hazard),    64'd0);
    m_vld = 0;
    @(negedge clk); rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
